// File: rtl/iter_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT/MADD/MSUB signed+unsigned, DIV/DIVU), one bit per cycle.
// Optional MDU_DIVZERO_FLAG_EN: zero-divisor divides skip CALC and raise div_zero_o with done_o.
module iter_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               cancel_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   op1_i,
   input  logic [WIDTH-1:0]   op2_i,
   input  logic [2*WIDTH-1:0] hilo_i,
   output logic               busy_o,
   output logic               done_o,
`ifdef MDU_DIVZERO_FLAG_EN
   output logic               div_zero_o,
`endif
   output logic [2*WIDTH-1:0] result_o
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   localparam logic [1:0] KindMul  = 2'b00;
   localparam logic [1:0] KindMadd = 2'b01;
   localparam logic [1:0] KindMsub = 2'b10;
   localparam logic [1:0] KindDiv  = 2'b11;

   typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [1:0]         kind_q, kind_d;
   logic               sgn_q, sgn_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic [2*WIDTH-1:0] hilo_q, hilo_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               done_q, done_d;
`ifdef MDU_DIVZERO_FLAG_EN
   logic               dz_q, dz_d;
   logic               div_zero_q, div_zero_d;
`endif

   // Accept-cycle decode. A zero-divisor divide is run unsigned on the raw dividend so that
   // restoring division naturally leaves Hi=op1_i and Lo=all ones.
   logic             op_is_div;
   logic             div_by_zero;
   logic             eff_signed;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;

   assign op_is_div   = (op_i[2:1] == KindDiv);
   assign div_by_zero = op_is_div && (op2_i == '0);
   assign eff_signed  = ~op_i[0] & ~div_by_zero;
   assign mag1        = (eff_signed && op1_i[WIDTH-1]) ? -op1_i : op1_i;
   assign mag2        = (eff_signed && op2_i[WIDTH-1]) ? -op2_i : op2_i;

   // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;

   assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};
   assign div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, opb_q};
   assign div_next  = div_trial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

   logic               neg_prod;
   logic               neg_rem;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [2*WIDTH-1:0] fin_result;

   assign neg_prod = sgn_q & (s1_q ^ s2_q);
   assign neg_rem  = sgn_q & s1_q;
   assign prod_s   = neg_prod ? -work_q : work_q;
   assign quo_s    = neg_prod ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
   assign rem_s    = neg_rem ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

   always_comb begin
      fin_result = prod_s;
      case (kind_q)
         KindMul:  fin_result = prod_s;
         KindMadd: fin_result = hilo_q + prod_s;
         KindMsub: fin_result = hilo_q - prod_s;
         default:  fin_result = {rem_s, quo_s};
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      kind_d   = kind_q;
      sgn_d    = sgn_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      hilo_d   = hilo_q;
      opb_d    = opb_q;
      work_d   = work_q;
      result_d = result_q;
      done_d   = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_d       = dz_q;
      div_zero_d = 1'b0;
`endif
      if (cancel_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               state_d = StIdle;
               if (start_i) begin
                  state_d = StCalc;
                  cnt_d   = '0;
                  kind_d  = op_i[2:1];
                  sgn_d   = eff_signed;
                  s1_d    = op1_i[WIDTH-1];
                  s2_d    = op2_i[WIDTH-1];
                  hilo_d  = hilo_i;
                  if (op_is_div) begin
                     opb_d  = mag2;
                     work_d = {{WIDTH{1'b0}}, mag1};
                  end else begin
                     opb_d  = mag1;
                     work_d = {{WIDTH{1'b0}}, mag2};
                  end
`ifdef MDU_DIVZERO_FLAG_EN
                  dz_d = div_by_zero;
                  if (div_by_zero) begin
                     state_d = StFin;
                     work_d  = {op1_i, {WIDTH{1'b1}}};
                  end
`endif
               end
            end
            StCalc: begin
               cnt_d  = cnt_q + 1'b1;
               work_d = (kind_q == KindDiv) ? div_next : mul_next;
               if (cnt_q == CntLast) state_d = StFin;
            end
            StFin: begin
               state_d  = StDone;
               done_d   = 1'b1;
               result_d = fin_result;
`ifdef MDU_DIVZERO_FLAG_EN
               div_zero_d = dz_q;
`endif
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         kind_q   <= '0;
         sgn_q    <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         hilo_q   <= '0;
         opb_q    <= '0;
         work_q   <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
         dz_q       <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         kind_q   <= kind_d;
         sgn_q    <= sgn_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         hilo_q   <= hilo_d;
         opb_q    <= opb_d;
         work_q   <= work_d;
         result_q <= result_d;
         done_q   <= done_d;
`ifdef MDU_DIVZERO_FLAG_EN
         dz_q       <= dz_d;
         div_zero_q <= div_zero_d;
`endif
      end
   end

   assign busy_o   = (state_q == StCalc) || (state_q == StFin);
   assign done_o   = done_q;
   assign result_o = result_q;
`ifdef MDU_DIVZERO_FLAG_EN
   assign div_zero_o = div_zero_q;
`endif

endmodule
